// File: rtl/pulse_pair_meter.sv
// ---------------------------------------------------------------------------
// pulse_pair_meter
//
// Measures the shaped pulse pair coming from the pulse-shaping stage. For every
// X period (rise to rise) it reports the period length, the X high width and
// the delay from the X rise to the first Y rise, all in sysclk cycles. Each
// finished measurement is latched and announced with a one-cycle strobe.
// Missing Y pulses and a lost X signal are flagged.
//
// Parameters
//   CNT_W        width of the cycle counter and of all measurement outputs
//   TIMEOUT_CYC  cycles without an X rise before No_Signal asserts
//                (must be below 2^CNT_W)
//
// Ports
//   sysclk      in   system clock, rising edge
//   sysrst      in   synchronous active-high reset
//   Meas_En     in   1 = measure, 0 = go idle and hold the last results
//   Pulse_X     in   reference pulse (synchronous to sysclk)
//   Pulse_Y     in   companion pulse (synchronous to sysclk)
//   Period      out  X rise-to-rise period
//   High_W      out  X high time
//   Delay_XY    out  X rise to first Y rise
//   Meas_Valid  out  one-cycle strobe when new results are latched
//   Y_Miss      out  no Y rise in the last measured period
//   No_Signal   out  X timeout occurred (also set out of reset)
//   Meas_Cnt    out  completed measurement count, wraps 255 -> 0
// ---------------------------------------------------------------------------
module pulse_pair_meter #(
    parameter int CNT_W       = 24,
    parameter int TIMEOUT_CYC = 10_000_000
) (
    input  logic             sysclk,
    input  logic             sysrst,
    input  logic             Meas_En,
    input  logic             Pulse_X,
    input  logic             Pulse_Y,
    output logic [CNT_W-1:0] Period,
    output logic [CNT_W-1:0] High_W,
    output logic [CNT_W-1:0] Delay_XY,
    output logic             Meas_Valid,
    output logic             Y_Miss,
    output logic             No_Signal,
    output logic [7:0]       Meas_Cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state, state_nxt;

    logic             x_q, x_d, y_q, y_d;
    logic             x_rise, x_fall, y_rise;

    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [CNT_W-1:0] w_tmp, w_tmp_nxt;
    logic [CNT_W-1:0] d_tmp, d_tmp_nxt;
    logic             y_seen, y_seen_nxt;

    logic [CNT_W-1:0] period_nxt, high_w_nxt, delay_xy_nxt;
    logic             valid_nxt, y_miss_nxt, no_signal_nxt;
    logic [7:0]       meas_cnt_nxt;

    // Both pulses go through the same two-stage pipeline so their relative
    // timing is untouched; edges are taken between the two stages.
    always_ff @(posedge sysclk) begin
        if (sysrst) begin
            x_q <= 1'b0;
            x_d <= 1'b0;
            y_q <= 1'b0;
            y_d <= 1'b0;
        end else begin
            x_q <= Pulse_X;
            x_d <= x_q;
            y_q <= Pulse_Y;
            y_d <= y_q;
        end
    end

    assign x_rise = x_q & ~x_d;
    assign x_fall = ~x_q & x_d;
    assign y_rise = y_q & ~y_d;

    // Counter increment that sticks at all-ones instead of wrapping.
    assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_ONE;

    // State and measurement registers.
    always_ff @(posedge sysclk) begin
        if (sysrst) begin
            state      <= IDLE;
            cnt        <= '0;
            w_tmp      <= '0;
            d_tmp      <= '0;
            y_seen     <= 1'b0;
            Period     <= '0;
            High_W     <= '0;
            Delay_XY   <= '0;
            Meas_Valid <= 1'b0;
            Y_Miss     <= 1'b0;
            No_Signal  <= 1'b1;
            Meas_Cnt   <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            w_tmp      <= w_tmp_nxt;
            d_tmp      <= d_tmp_nxt;
            y_seen     <= y_seen_nxt;
            Period     <= period_nxt;
            High_W     <= high_w_nxt;
            Delay_XY   <= delay_xy_nxt;
            Meas_Valid <= valid_nxt;
            Y_Miss     <= y_miss_nxt;
            No_Signal  <= no_signal_nxt;
            Meas_Cnt   <= meas_cnt_nxt;
        end
    end

    // Next-state and capture logic. ARMED and MEASURE share the same capture
    // rules; ARMED only marks that the period in progress is the first one
    // after arming, so its closing X rise is the first that can report.
    // Every X rise that closes a period also opens the next one, so
    // back-to-back periods are measured without gaps. A Y rise coincident
    // with the opening X rise counts as delay 0.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        w_tmp_nxt     = w_tmp;
        d_tmp_nxt     = d_tmp;
        y_seen_nxt    = y_seen;
        period_nxt    = Period;
        high_w_nxt    = High_W;
        delay_xy_nxt  = Delay_XY;
        valid_nxt     = 1'b0;
        y_miss_nxt    = Y_Miss;
        no_signal_nxt = No_Signal;
        meas_cnt_nxt  = Meas_Cnt;

        if (!Meas_En) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_nxt = '0;
                    if (x_rise) begin
                        state_nxt  = ARMED;
                        cnt_nxt    = CNT_ONE;
                        w_tmp_nxt  = '0;
                        d_tmp_nxt  = '0;
                        y_seen_nxt = y_rise;
                    end
                end

                ARMED, MEASURE: begin
                    if (x_rise) begin
                        state_nxt     = MEASURE;
                        period_nxt    = cnt;
                        high_w_nxt    = w_tmp;
                        delay_xy_nxt  = y_seen ? d_tmp : '0;
                        y_miss_nxt    = ~y_seen;
                        valid_nxt     = 1'b1;
                        meas_cnt_nxt  = Meas_Cnt + 8'd1;
                        no_signal_nxt = 1'b0;
                        cnt_nxt       = CNT_ONE;
                        d_tmp_nxt     = '0;
                        y_seen_nxt    = y_rise;
                    end else if (cnt >= TIMEOUT_VAL) begin
                        // X stuck high or low: give up, keep the old results.
                        state_nxt     = IDLE;
                        cnt_nxt       = '0;
                        no_signal_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc;
                        if (x_fall) begin
                            w_tmp_nxt = cnt;
                        end
                        if (y_rise && !y_seen) begin
                            d_tmp_nxt  = cnt;
                            y_seen_nxt = 1'b1;
                        end
                    end
                end

                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_pair_meter.sv
// ---------------------------------------------------------------------------
// tb_pulse_pair_meter
//
// Self-checking bench for pulse_pair_meter. Each X period is generated from a
// vector record; when an X rise closes a measurable period the expected
// results are pushed to a queue, and a monitor pops and compares them when
// Meas_Valid appears. Hand-written sequences cover timeout, enable drop,
// reset with a coincident X rise and counter wrap.
// ---------------------------------------------------------------------------
module tb_pulse_pair_meter;

    localparam int CNT_W   = 24;
    localparam int TIMEOUT = 100;

    logic             sysclk;
    logic             sysrst;
    logic             Meas_En;
    logic             Pulse_X;
    logic             Pulse_Y;
    logic [CNT_W-1:0] Period;
    logic [CNT_W-1:0] High_W;
    logic [CNT_W-1:0] Delay_XY;
    logic             Meas_Valid;
    logic             Y_Miss;
    logic             No_Signal;
    logic [7:0]       Meas_Cnt;

    pulse_pair_meter #(
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .sysclk     (sysclk),
        .sysrst     (sysrst),
        .Meas_En    (Meas_En),
        .Pulse_X    (Pulse_X),
        .Pulse_Y    (Pulse_Y),
        .Period     (Period),
        .High_W     (High_W),
        .Delay_XY   (Delay_XY),
        .Meas_Valid (Meas_Valid),
        .Y_Miss     (Y_Miss),
        .No_Signal  (No_Signal),
        .Meas_Cnt   (Meas_Cnt)
    );

    // One X period: length, high width, Y pulse positions (-1 = none) and the
    // results this period must produce once it is closed by the next X rise.
    typedef struct {
        int period;
        int high;
        int yd;
        int y2;
        int reps;
        int eDelay;
        bit eMiss;
    } vec_t;

    typedef struct {
        int period;
        int high;
        int delay;
        bit miss;
        int cnt;
    } exp_t;

    exp_t    sbq[$];
    vec_t    vecs[6];
    vec_t    prevV;
    vec_t    steady;
    vec_t    other;
    vec_t    fast;
    bit      armed;
    int      expCnt;
    int      total;
    int      bad;
    longint  cyc;
    longint  lastRiseCyc;
    longint  lastValidCyc;

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input longint act, input longint expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0d required %0d", name, act, expv);
        end
    endtask

    // Drives one X period from negedge to negedge. The X rise at the start
    // closes the previous period, so that is where its expectation is pushed.
    task automatic applyStimulus(input vec_t v, input logic enable);
        exp_t e;
        for (int c = 0; c < v.period; c++) begin
            @(negedge sysclk);
            if (c == 0) begin
                Meas_En = enable;
                if (enable && armed) begin
                    expCnt   = (expCnt + 1) % 256;
                    e.period = prevV.period;
                    e.high   = prevV.high;
                    e.delay  = prevV.eDelay;
                    e.miss   = prevV.eMiss;
                    e.cnt    = expCnt;
                    sbq.push_back(e);
                end
                armed       = enable;
                prevV       = v;
                lastRiseCyc = cyc;
            end
            Pulse_X = (c < v.high);
            Pulse_Y = (c == v.yd) || (c == v.y2);
        end
    endtask

    // Monitor: a strobe is expected two edges after the X rise was driven,
    // i.e. during the third clock cycle counting the X rise cycle as first.
    always @(posedge sysclk) begin
        exp_t e;
        cyc++;
        #1;
        if (Meas_Valid) begin
            lastValidCyc = cyc;
            checkOutput("valid_latency", cyc - lastRiseCyc, 2);
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_valid: got Meas_Valid=1 required 0");
            end else begin
                e = sbq.pop_front();
                checkOutput("period",    longint'(Period),    e.period);
                checkOutput("high_w",    longint'(High_W),    e.high);
                checkOutput("delay_xy",  longint'(Delay_XY),  e.delay);
                checkOutput("y_miss",    longint'(Y_Miss),    longint'(e.miss));
                checkOutput("meas_cnt",  longint'(Meas_Cnt),  e.cnt);
                checkOutput("no_signal", longint'(No_Signal), 0);
            end
        end
    end

    initial begin
        bit found;

        total        = 0;
        bad          = 0;
        cyc          = 0;
        lastRiseCyc  = 0;
        lastValidCyc = 0;
        armed        = 1'b0;
        expCnt       = 0;

        //            period high yd  y2 reps eDelay eMiss
        vecs[0] = '{10, 3,  2, -1, 6, 2, 1'b0};
        vecs[1] = '{ 7, 4,  0,  3, 4, 0, 1'b0};
        vecs[2] = '{12, 5, -1, -1, 3, 0, 1'b1};
        vecs[3] = '{12, 5,  4, -1, 3, 4, 1'b0};
        vecs[4] = '{ 9, 8,  8, -1, 3, 8, 1'b0};
        vecs[5] = '{ 2, 1,  1, -1, 4, 1, 1'b0};
        steady  = vecs[0];
        other   = '{10, 6,  5, -1, 1, 5, 1'b0};
        fast    = '{ 4, 1,  1, -1, 1, 1, 1'b0};

        sysrst  = 1'b1;
        Meas_En = 1'b0;
        Pulse_X = 1'b0;
        Pulse_Y = 1'b0;
        repeat (3) @(negedge sysclk);
        sysrst = 1'b0;
        @(negedge sysclk);
        checkOutput("rst_period",    longint'(Period),     0);
        checkOutput("rst_high_w",    longint'(High_W),     0);
        checkOutput("rst_delay",     longint'(Delay_XY),   0);
        checkOutput("rst_valid",     longint'(Meas_Valid), 0);
        checkOutput("rst_y_miss",    longint'(Y_Miss),     0);
        checkOutput("rst_no_signal", longint'(No_Signal),  1);
        checkOutput("rst_meas_cnt",  longint'(Meas_Cnt),   0);

        // Table-driven periods, run back to back.
        for (int i = 0; i < 6; i++) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                applyStimulus(vecs[i], 1'b1);
            end
        end

        // Timeout: five good periods, then X stays low.
        $display("[TB] timeout sequence");
        for (int r = 0; r < 5; r++) applyStimulus(steady, 1'b1);
        Pulse_X = 1'b0;
        Pulse_Y = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 3 * TIMEOUT; i++) begin
            @(posedge sysclk);
            #2;
            if (No_Signal) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("timeout_seen", longint'(found), 1);
        checkOutput("timeout_delay", cyc - lastValidCyc, TIMEOUT);
        checkOutput("hold_period", longint'(Period),   10);
        checkOutput("hold_high_w", longint'(High_W),   3);
        checkOutput("hold_delay",  longint'(Delay_XY), 2);
        armed = 1'b0;
        applyStimulus(steady, 1'b1);
        checkOutput("no_signal_after_1st_rise", longint'(No_Signal), 1);
        for (int r = 0; r < 2; r++) applyStimulus(steady, 1'b1);
        checkOutput("no_signal_cleared", longint'(No_Signal), 0);

        // Enable dropped for 30 cycles while X keeps running with a different
        // shape; nothing may be latched during that time.
        $display("[TB] enable drop sequence");
        for (int r = 0; r < 3; r++) applyStimulus(other, 1'b0);
        checkOutput("en_hold_high_w", longint'(High_W),   3);
        checkOutput("en_hold_delay",  longint'(Delay_XY), 2);
        checkOutput("en_hold_cnt",    longint'(Meas_Cnt), expCnt);
        for (int r = 0; r < 3; r++) applyStimulus(steady, 1'b1);

        // Reset coincident with the internal X rise, single-cycle X pulse.
        $display("[TB] reset sequence");
        @(negedge sysclk);
        Pulse_X = 1'b1;
        Pulse_Y = 1'b0;
        @(negedge sysclk);
        Pulse_X = 1'b0;
        sysrst  = 1'b1;
        @(negedge sysclk);
        sysrst  = 1'b0;
        armed   = 1'b0;
        expCnt  = 0;
        checkOutput("rst2_pending", sbq.size(), 0);
        checkOutput("rst2_period",    longint'(Period),    0);
        checkOutput("rst2_no_signal", longint'(No_Signal), 1);
        checkOutput("rst2_meas_cnt",  longint'(Meas_Cnt),  0);
        for (int r = 0; r < 3; r++) applyStimulus(steady, 1'b1);

        // Enough measurements to wrap the 8-bit counter.
        $display("[TB] counter wrap sequence");
        for (int r = 0; r < 260; r++) applyStimulus(fast, 1'b1);

        @(negedge sysclk);
        Pulse_X = 1'b0;
        Pulse_Y = 1'b0;
        repeat (5) @(negedge sysclk);
        checkOutput("sb_drained", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
